// File: rtl/stack_sequencer.sv
// Command sequencer for the register stack: turns stack-machine commands into
// primitive stack-op cycles, computes ALU write data and tracks occupancy.
module stack_sequencer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64,
    parameter int DW    = 7
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [2:0]       stack_op,
    output logic [WIDTH-1:0] stack_w,
    output logic             stack_clr,
    output logic             cmd_done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [DW-1:0]    depth
);

    typedef enum logic [1:0] {IDLE, SW1, SW2} state_t;

    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_REPL = 3'd2;
    localparam logic [2:0] OP_POP  = 3'd3;
    localparam logic [2:0] OP_POP2 = 3'd4;

    localparam logic [DW-1:0] FULL = DW'(DEPTH);
    localparam logic [DW-1:0] ONE  = DW'(1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a0, b0, a0_nxt, b0_nxt;
    logic [2:0]       op_nxt;
    logic [WIDTH-1:0] w_nxt;
    logic             clr_nxt, done_nxt, err_nxt;
    logic [1:0]       code_nxt;
    logic [DW-1:0]    depth_nxt;
    logic [DW-1:0]    need_min;
    logic             grows;
    logic             illegal;

    assign cmd_ready = (state == IDLE);

    // Minimum occupancy and growth per opcode, used for under/overflow checks.
    always_comb begin
        need_min = '0;
        grows    = 1'b0;
        illegal  = 1'b0;
        case (cmd)
            4'd1:                         grows = 1'b1;
            4'd2:    need_min = ONE;
            4'd3: begin need_min = ONE;   grows = 1'b1; end
            4'd4:    need_min = DW'(2);
            4'd5: begin need_min = DW'(2); grows = 1'b1; end
            4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11: need_min = DW'(2);
            4'd0, 4'd12: need_min = '0;
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        op_nxt    = 3'd0;
        w_nxt     = stack_w;
        clr_nxt   = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        code_nxt  = err_code;
        depth_nxt = depth;
        a0_nxt    = a0;
        b0_nxt    = b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (illegal) begin
                        err_nxt  = 1'b1;
                        code_nxt = 2'd3;
                    end else if (depth < need_min) begin
                        err_nxt  = 1'b1;
                        code_nxt = 2'd1;
                    end else if (grows && depth == FULL) begin
                        err_nxt  = 1'b1;
                        code_nxt = 2'd2;
                    end else begin
                        done_nxt = 1'b1;
                        case (cmd)
                            4'd1: begin op_nxt = OP_PUSH; w_nxt = imm; depth_nxt = depth + ONE; end
                            4'd2: begin op_nxt = OP_POP;              depth_nxt = depth - ONE; end
                            4'd3: begin op_nxt = OP_PUSH; w_nxt = a;   depth_nxt = depth + ONE; end
                            4'd4: begin
                                // Pop both, then push them back in reverse order.
                                op_nxt    = OP_POP2;
                                a0_nxt    = a;
                                b0_nxt    = b;
                                done_nxt  = 1'b0;
                                state_nxt = SW1;
                            end
                            4'd5:  begin op_nxt = OP_PUSH; w_nxt = b;     depth_nxt = depth + ONE; end
                            4'd6:  begin op_nxt = OP_REPL; w_nxt = b + a; depth_nxt = depth - ONE; end
                            4'd7:  begin op_nxt = OP_REPL; w_nxt = b - a; depth_nxt = depth - ONE; end
                            4'd8:  begin op_nxt = OP_REPL; w_nxt = b & a; depth_nxt = depth - ONE; end
                            4'd9:  begin op_nxt = OP_REPL; w_nxt = b | a; depth_nxt = depth - ONE; end
                            4'd10: begin op_nxt = OP_REPL; w_nxt = b ^ a; depth_nxt = depth - ONE; end
                            4'd11: begin op_nxt = OP_REPL; w_nxt = a;     depth_nxt = depth - ONE; end
                            4'd12: begin clr_nxt = 1'b1; depth_nxt = '0; end
                            default: ;
                        endcase
                    end
                end
            end
            SW1: begin
                op_nxt    = OP_PUSH;
                w_nxt     = a0;
                state_nxt = SW2;
            end
            SW2: begin
                op_nxt    = OP_PUSH;
                w_nxt     = b0;
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            stack_op  <= 3'd0;
            stack_w   <= '0;
            stack_clr <= 1'b0;
            cmd_done  <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'd0;
            depth     <= '0;
            a0        <= '0;
            b0        <= '0;
        end else begin
            state     <= state_nxt;
            stack_op  <= op_nxt;
            stack_w   <= w_nxt;
            stack_clr <= clr_nxt;
            cmd_done  <= done_nxt;
            err       <= err_nxt;
            err_code  <= code_nxt;
            depth     <= depth_nxt;
            a0        <= a0_nxt;
            b0        <= b0_nxt;
        end
    end

endmodule

// File: tb/tb_stack_sequencer.sv
// Scoreboard bench for stack_sequencer: directed commands queue expected output
// cycles, a forked monitor pops and compares them; a small stack emulates the RAM.
module tb_stack_sequencer;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd = 4'd0;
    logic [15:0] imm = 16'd0;
    logic [15:0] a, b;
    logic [2:0]  stack_op;
    logic [15:0] stack_w;
    logic        stack_clr, cmd_done, err;
    logic [1:0]  err_code;
    logic [6:0]  depth;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] w;
        bit          chk_w;
        bit          done;
        bit          er;
        logic [1:0]  code;
        bit          clr;
        logic [6:0]  dep;
    } exp_t;

    exp_t        q[$];
    logic [15:0] stk [0:63];
    int          sp = 0;
    int          compared = 0;
    int          mismatched = 0;

    assign a = (sp >= 1) ? stk[sp-1] : 16'd0;
    assign b = (sp >= 2) ? stk[sp-2] : 16'd0;

    always #5 CLK = ~CLK;

    stack_sequencer #(.WIDTH(16), .DEPTH(64), .DW(7)) dut (
        .CLK(CLK), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd(cmd), .imm(imm), .a(a), .b(b), .stack_op(stack_op), .stack_w(stack_w),
        .stack_clr(stack_clr), .cmd_done(cmd_done), .err(err), .err_code(err_code),
        .depth(depth)
    );

    task automatic expect_cyc(input logic [2:0] op, input logic [15:0] w, input bit chk_w,
                              input bit done, input bit er, input logic [1:0] code,
                              input bit clr, input logic [6:0] dep);
        exp_t e;
        e.op = op; e.w = w; e.chk_w = chk_w; e.done = done; e.er = er;
        e.code = code; e.clr = clr; e.dep = dep;
        q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic issue(input logic [3:0] c, input logic [15:0] i);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!cmd_ready) begin
            compared++; mismatched++;
            $display("FAIL ready_timeout: cmd_ready=0 after %0d cycles, expected 1", n);
        end
        cmd = c; imm = i; cmd_valid = 1'b1;
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
    endtask

    // Monitor: one comparison per cycle in which the DUT presents activity.
    task automatic monitor_step();
        exp_t e;
        if (reset) return;
        if (stack_op != 3'd0 || cmd_done || err || stack_clr) begin
            compared++;
            if (q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_cycle: op=%0d w=0x%0h done=%0d err=%0d clr=%0d, expected no activity",
                         stack_op, stack_w, cmd_done, err, stack_clr);
            end else begin
                e = q.pop_front();
                if (stack_op !== e.op || (e.chk_w && stack_w !== e.w) || cmd_done !== e.done ||
                    err !== e.er || err_code !== e.code || stack_clr !== e.clr || depth !== e.dep) begin
                    mismatched++;
                    $display("FAIL cycle_check: got op=%0d w=0x%0h done=%0d err=%0d code=%0d clr=%0d depth=%0d, expected op=%0d w=0x%0h done=%0d err=%0d code=%0d clr=%0d depth=%0d",
                             stack_op, stack_w, cmd_done, err, err_code, stack_clr, depth,
                             e.op, e.w, e.done, e.er, e.code, e.clr, e.dep);
                end
            end
        end
        // Stack commit on the falling edge, as the register stack does.
        case (stack_op)
            3'd1: if (sp < 64) begin stk[sp] = stack_w; sp = sp + 1; end
            3'd2: if (sp >= 2) begin sp = sp - 1; stk[sp-1] = stack_w; end
            3'd3: if (sp >= 1) sp = sp - 1;
            3'd4: if (sp >= 2) sp = sp - 2;
            default: ;
        endcase
        if (stack_clr) sp = 0;
    endtask

    initial begin
        fork
            forever begin
                @(negedge CLK);
                monitor_step();
            end
        join_none

        repeat (2) @(posedge CLK);
        #1 reset = 1'b0;
        check("rst_stack_op", 32'(stack_op), 0);
        check("rst_stack_w", 32'(stack_w), 0);
        check("rst_flags", {29'd0, stack_clr, cmd_done, err}, 0);
        check("rst_err_code", 32'(err_code), 0);
        check("rst_depth", 32'(depth), 0);
        check("rst_ready", 32'(cmd_ready), 1);

        // Back-to-back pushes
        expect_cyc(3'd1, 16'h0003, 1, 1, 0, 2'd0, 0, 7'd1);
        issue(4'd1, 16'h0003);
        check("push_ready_high", 32'(cmd_ready), 1);
        expect_cyc(3'd1, 16'h0005, 1, 1, 0, 2'd0, 0, 7'd2);
        issue(4'd1, 16'h0005);

        // SUB wraps, then ADD underflows
        expect_cyc(3'd2, 16'hFFFE, 1, 1, 0, 2'd0, 0, 7'd1);
        issue(4'd7, 16'h0000);
        expect_cyc(3'd0, 16'h0000, 0, 0, 1, 2'd1, 0, 7'd1);
        issue(4'd6, 16'h0000);

        // SWAP
        expect_cyc(3'd0, 16'h0000, 0, 1, 0, 2'd1, 1, 7'd0);
        issue(4'd12, 16'h0000);
        expect_cyc(3'd1, 16'h2222, 1, 1, 0, 2'd1, 0, 7'd1);
        issue(4'd1, 16'h2222);
        expect_cyc(3'd1, 16'h1111, 1, 1, 0, 2'd1, 0, 7'd2);
        issue(4'd1, 16'h1111);
        expect_cyc(3'd4, 16'h0000, 0, 0, 0, 2'd1, 0, 7'd2);
        expect_cyc(3'd1, 16'h1111, 1, 0, 0, 2'd1, 0, 7'd2);
        expect_cyc(3'd1, 16'h2222, 1, 1, 0, 2'd1, 0, 7'd2);
        issue(4'd4, 16'h0000);
        check("swap_ready_sw1", 32'(cmd_ready), 0);
        @(posedge CLK); #1;
        check("swap_ready_sw2", 32'(cmd_ready), 0);
        @(posedge CLK); #1;
        check("swap_ready_back", 32'(cmd_ready), 1);
        @(negedge CLK); #1;
        check("swap_a", 32'(a), 32'h2222);
        check("swap_b", 32'(b), 32'h1111);
        check("swap_depth", 32'(depth), 2);

        // Fill to capacity, then overflow on PUSH and DUP, then CLR
        expect_cyc(3'd0, 16'h0000, 0, 1, 0, 2'd1, 1, 7'd0);
        issue(4'd12, 16'h0000);
        for (int i = 0; i < 64; i++) begin
            expect_cyc(3'd1, 16'(i + 16'h0100), 1, 1, 0, 2'd1, 0, 7'(i + 1));
            issue(4'd1, 16'(i + 16'h0100));
        end
        expect_cyc(3'd0, 16'h0000, 0, 0, 1, 2'd2, 0, 7'd64);
        issue(4'd1, 16'hDEAD);
        expect_cyc(3'd0, 16'h0000, 0, 0, 1, 2'd2, 0, 7'd64);
        issue(4'd3, 16'h0000);
        expect_cyc(3'd0, 16'h0000, 0, 1, 0, 2'd2, 1, 7'd0);
        issue(4'd12, 16'h0000);

        // Illegal opcode, DROP underflow at empty, NOP
        expect_cyc(3'd0, 16'h0000, 0, 0, 1, 2'd3, 0, 7'd0);
        issue(4'd14, 16'h0000);
        expect_cyc(3'd0, 16'h0000, 0, 0, 1, 2'd1, 0, 7'd0);
        issue(4'd2, 16'h0000);
        expect_cyc(3'd0, 16'h0000, 0, 0, 1, 2'd3, 0, 7'd0);
        issue(4'd15, 16'h0000);
        expect_cyc(3'd0, 16'h0000, 0, 1, 0, 2'd3, 0, 7'd0);
        issue(4'd0, 16'h0000);
        check("nop_err_code_held", 32'(err_code), 3);

        // OVER and XOR/NIP on a small stack
        expect_cyc(3'd1, 16'h00F0, 1, 1, 0, 2'd3, 0, 7'd1);
        issue(4'd1, 16'h00F0);
        expect_cyc(3'd1, 16'h0F0F, 1, 1, 0, 2'd3, 0, 7'd2);
        issue(4'd1, 16'h0F0F);
        expect_cyc(3'd1, 16'h00F0, 1, 1, 0, 2'd3, 0, 7'd3);
        issue(4'd5, 16'h0000);
        expect_cyc(3'd2, 16'h0FFF, 1, 1, 0, 2'd3, 0, 7'd2);
        issue(4'd10, 16'h0000);
        expect_cyc(3'd2, 16'h0FFF, 1, 1, 0, 2'd3, 0, 7'd1);
        issue(4'd11, 16'h0000);

        // Reset during SW1 aborts the SWAP
        expect_cyc(3'd1, 16'hAAAA, 1, 1, 0, 2'd3, 0, 7'd2);
        issue(4'd1, 16'hAAAA);
        expect_cyc(3'd4, 16'h0000, 0, 0, 0, 2'd3, 0, 7'd2);
        issue(4'd4, 16'h0000);
        @(negedge CLK); #1;
        reset = 1'b1;
        sp = 0;
        #1;
        check("abort_stack_op", 32'(stack_op), 0);
        check("abort_depth", 32'(depth), 0);
        q.delete();
        @(posedge CLK); #1;
        reset = 1'b0;
        check("abort_ready", 32'(cmd_ready), 1);
        repeat (5) @(posedge CLK);
        #1;
        check("abort_no_push_depth", 32'(depth), 0);

        begin
            int n = 0;
            while (q.size() != 0 && n < 20) begin
                @(posedge CLK);
                n++;
            end
        end
        check("queue_drained", 32'(q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
